// File: rtl/vmem_arbiter_if.sv
// Bus bundle for vmem_arbiter: VGA read port, CPU write/flush port and memory port.
// The arbiter uses the slave modport; the surrounding system uses master.
interface vmem_arbiter_if #(
    parameter int DEPTH = 4
);
    logic                       VGA_RD;
    logic [13:0]                VGA_ADDR;
    logic [14:0]                VGA_DATA;
    logic                       VGA_VALID;
    logic                       CPU_WE;
    logic [13:0]                CPU_ADDR;
    logic [14:0]                CPU_WDATA;
    logic                       CPU_READY;
    logic                       FLUSH_REQ;
    logic                       FLUSH_ACK;
    logic                       DROP;
    logic [$clog2(DEPTH):0]     FIFO_COUNT;
    logic [13:0]                MEM_ADDR;
    logic                       MEM_WE;
    logic [14:0]                MEM_WDATA;
    logic [14:0]                MEM_RDATA;

    modport slave (
        input  VGA_RD, VGA_ADDR, CPU_WE, CPU_ADDR, CPU_WDATA, FLUSH_REQ, MEM_RDATA,
        output VGA_DATA, VGA_VALID, CPU_READY, FLUSH_ACK, DROP, FIFO_COUNT,
               MEM_ADDR, MEM_WE, MEM_WDATA
    );

    modport master (
        output VGA_RD, VGA_ADDR, CPU_WE, CPU_ADDR, CPU_WDATA, FLUSH_REQ, MEM_RDATA,
        input  VGA_DATA, VGA_VALID, CPU_READY, FLUSH_ACK, DROP, FIFO_COUNT,
               MEM_ADDR, MEM_WE, MEM_WDATA
    );
endinterface

// File: rtl/vmem_arbiter.sv
// Video memory arbiter: VGA reads win the single memory port, CPU writes queue in a FIFO.
// Optional write coalescing into the tail entry is enabled by defining VMEM_WRITE_COALESCE_EN.
module vmem_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic            PIXEL_CLK,
    input  logic            RESET,
    vmem_arbiter_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {RUN, FLUSH} state_t;

    state_t         state_reg, state_next;
    logic [13:0]    addr_mem [DEPTH];
    logic [14:0]    data_mem [DEPTH];
    logic [PW-1:0]  head_reg, tail_reg, tail_last;
    logic [CW-1:0]  count_reg;
    logic           vga_valid_reg;
    logic           flush_ack_reg, flush_ack_next;
    logic           drop_reg;
    logic           cpu_ready, pop, push, push_new, coalesce;

    // Ready is derived from registers only, so a full FIFO stays not-ready even while popping.
    assign cpu_ready = (state_reg == RUN) && (count_reg < CW'(DEPTH));
    assign pop       = !bus.VGA_RD && (count_reg != '0);
    assign push      = bus.CPU_WE && cpu_ready;
    assign tail_last = tail_reg - PW'(1);

`ifdef VMEM_WRITE_COALESCE_EN
    assign coalesce = push && (count_reg != '0) && (bus.CPU_ADDR == addr_mem[tail_last])
                      && !((count_reg == CW'(1)) && pop);
`else
    assign coalesce = 1'b0;
`endif
    assign push_new = push && !coalesce;

    // FIFO storage: no reset needed, occupancy is tracked by the pointers and count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic wr_en;
            assign wr_en = (push_new && (tail_reg == PW'(gi))) || (coalesce && (tail_last == PW'(gi)));
            always_ff @(posedge PIXEL_CLK) begin
                if (wr_en) begin
                    addr_mem[gi] <= bus.CPU_ADDR;
                    data_mem[gi] <= bus.CPU_WDATA;
                end
            end
        end
    endgenerate

    always_comb begin
        bus.MEM_ADDR  = bus.VGA_ADDR;
        bus.MEM_WE    = 1'b0;
        bus.MEM_WDATA = data_mem[head_reg];
        if (pop) begin
            bus.MEM_ADDR = addr_mem[head_reg];
            bus.MEM_WE   = 1'b1;
        end
    end

    always_ff @(posedge PIXEL_CLK or posedge RESET) begin
        if (RESET) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            vga_valid_reg <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            head_reg      <= head_reg + PW'(pop);
            tail_reg      <= tail_reg + PW'(push_new);
            count_reg     <= count_reg + CW'(push_new) - CW'(pop);
            vga_valid_reg <= bus.VGA_RD;
            if (bus.CPU_WE && !cpu_ready) begin
                drop_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge PIXEL_CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= RUN;
            flush_ack_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_ack_reg <= flush_ack_next;
        end
    end

    // FLUSH blocks pushes, so the only way to reach empty is the last entry popping.
    always_comb begin
        state_next     = state_reg;
        flush_ack_next = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.FLUSH_REQ) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if ((count_reg == '0) || ((count_reg == CW'(1)) && pop)) begin
                    state_next     = RUN;
                    flush_ack_next = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign bus.VGA_DATA   = bus.MEM_RDATA;
    assign bus.VGA_VALID  = vga_valid_reg;
    assign bus.CPU_READY  = cpu_ready;
    assign bus.FLUSH_ACK  = flush_ack_reg;
    assign bus.DROP       = drop_reg;
    assign bus.FIFO_COUNT = count_reg;
endmodule
